// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC cascade logic.
//   seq_state_e    : INTA sequence state (IDLE, WAIT2, WAIT3)
//   VEC_PHASE_*    : byte index presented on the data bus for each INTA pulse
//   SPURIOUS_LVL   : all-ones level used when no interrupt was pending at pulse 1
//                    (slice to the CAS width in use)
//   PIC_CAS_W      : default CAS bus width
package pic_pkg;

  localparam int PIC_CAS_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT2 = 2'd1,
    WAIT3 = 2'd2
  } seq_state_e;

  localparam logic [1:0] VEC_PHASE_CALL = 2'd0;  // 8080 CALL opcode
  localparam logic [1:0] VEC_PHASE_LO   = 2'd1;  // vector / low address byte
  localparam logic [1:0] VEC_PHASE_HI   = 2'd2;  // high address byte

  localparam logic [31:0] SPURIOUS_LVL = '1;

endpackage

// File: rtl/inta_timeout_counter.sv
// Watchdog for the gap between consecutive INTA pulses.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the count from zero (has priority over enable)
//   enable     : count one clock
//   expired    : count has reached TIMEOUT-1
module inta_timeout_counter #(
  parameter int TIMEOUT = 64,
  localparam int CW     = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cascade_sequencer.sv
// Cascade controller for the PIC: follows the INTA pulse train (2 pulses in
// 8086 mode, 3 in 8080 mode), freezes the acknowledged level, drives the CAS
// bus as master or decodes it as slave, and decides whether this device puts
// the vector on the data bus. Aborts a sequence that stalls between pulses.
//   clk, reset     : system clock, synchronous active-high reset
//   sp, sngl, upm  : master/slave, single/cascade, 8086/8080 (sampled at pulse 1)
//   icw3           : master slave-present bitmap / slave own ID in low bits
//   ir_level/valid : winning request from the priority resolver
//   inta           : one-cycle strobe per INTA pulse
//   cas_in         : sampled CAS bus (slave)
//   cas_out/cas_oe : CAS drive (master)
//   vec_oe/phase   : data-bus ownership and byte index, aligned with inta
//   ack_set/level  : ISR set request and the acknowledged level
//   busy           : sequence in progress
//   seq_error      : one-cycle pulse when a sequence is aborted by timeout
module cascade_sequencer
  import pic_pkg::*;
#(
  parameter int CAS_W   = PIC_CAS_W,
  parameter int TIMEOUT = 64,
  localparam int N_PORTS = 2 ** CAS_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sp,
  input  logic               sngl,
  input  logic               upm,
  input  logic [N_PORTS-1:0] icw3,
  input  logic [CAS_W-1:0]   ir_level,
  input  logic               ir_valid,
  input  logic               inta,
  input  logic [CAS_W-1:0]   cas_in,
  output logic [CAS_W-1:0]   cas_out,
  output logic               cas_oe,
  output logic               vec_oe,
  output logic [1:0]         vec_phase,
  output logic               ack_set,
  output logic [CAS_W-1:0]   ack_level,
  output logic               busy,
  output logic               seq_error
);

  localparam logic [CAS_W-1:0] SPUR = SPURIOUS_LVL[CAS_W-1:0];

  seq_state_e state, state_n;

  logic [CAS_W-1:0] lvl_q, lvl_n;
  logic [CAS_W-1:0] cas_out_q, cas_out_n;
  logic [CAS_W-1:0] id_q, id_n;
  logic             casc_q, casc_n;
  logic             cas_oe_q, cas_oe_n;
  logic             sel_q, sel_n;
  logic             sp_q, sp_n;
  logic             sngl_q, sngl_n;
  logic             upm_q, upm_n;
  logic             ack_set_q, ack_set_n;
  logic             seq_error_q, seq_error_n;
  logic             sel_now;
  logic             expired;

  // Pulse-1 decisions, taken from live inputs.
  logic [CAS_W-1:0] p1_lvl;
  logic             p1_casc;
  assign p1_lvl  = ir_valid ? ir_level : SPUR;
  assign p1_casc = sp & ~sngl & ir_valid & icw3[p1_lvl];

  assign busy = (state != IDLE);

  // Restart on every pulse and whenever idle so each gap is timed from zero.
  inta_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (inta | ~busy | expired),
    .enable (busy),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q       <= SPUR;
      cas_out_q   <= SPUR;
      id_q        <= '0;
      casc_q      <= 1'b0;
      cas_oe_q    <= 1'b0;
      sel_q       <= 1'b0;
      sp_q        <= 1'b0;
      sngl_q      <= 1'b0;
      upm_q       <= 1'b0;
      ack_set_q   <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      lvl_q       <= lvl_n;
      cas_out_q   <= cas_out_n;
      id_q        <= id_n;
      casc_q      <= casc_n;
      cas_oe_q    <= cas_oe_n;
      sel_q       <= sel_n;
      sp_q        <= sp_n;
      sngl_q      <= sngl_n;
      upm_q       <= upm_n;
      ack_set_q   <= ack_set_n;
      seq_error_q <= seq_error_n;
    end
  end

  always_comb begin
    state_n     = state;
    lvl_n       = lvl_q;
    cas_out_n   = cas_out_q;
    id_n        = id_q;
    casc_n      = casc_q;
    cas_oe_n    = cas_oe_q;
    sel_n       = sel_q;
    sp_n        = sp_q;
    sngl_n      = sngl_q;
    upm_n       = upm_q;
    ack_set_n   = 1'b0;
    seq_error_n = 1'b0;
    vec_oe      = 1'b0;
    vec_phase   = VEC_PHASE_CALL;
    sel_now     = 1'b0;

    unique case (state)
      IDLE: begin
        if (inta) begin
          lvl_n  = p1_lvl;
          casc_n = p1_casc;
          sel_n  = 1'b0;
          sp_n   = sp;
          sngl_n = sngl;
          upm_n  = upm;
          id_n   = icw3[CAS_W-1:0];
          if (sp) begin
            cas_out_n = p1_lvl;
            cas_oe_n  = p1_casc;
            ack_set_n = ir_valid;
          end
          // Only the master answers pulse 1, and only with the 8080 CALL byte.
          vec_oe    = sp & ~upm;
          vec_phase = VEC_PHASE_CALL;
          state_n   = WAIT2;
        end
      end

      WAIT2: begin
        if (inta) begin
          // Master supplies the vector unless a slave owns this level.
          sel_now   = sp_q ? ~casc_q : (~sngl_q & (cas_in == id_q));
          sel_n     = sel_now;
          vec_oe    = sel_now;
          vec_phase = VEC_PHASE_LO;
          // A slave learns it was picked only now, so it acknowledges here.
          if (~sp_q & sel_now & ir_valid) begin
            lvl_n     = ir_level;
            ack_set_n = 1'b1;
          end
          if (upm_q) begin
            state_n  = IDLE;
            cas_oe_n = 1'b0;
          end else begin
            state_n  = WAIT3;
          end
        end else if (expired) begin
          state_n     = IDLE;
          cas_oe_n    = 1'b0;
          seq_error_n = 1'b1;
        end
      end

      WAIT3: begin
        if (inta) begin
          vec_oe    = sel_q;
          vec_phase = VEC_PHASE_HI;
          state_n   = IDLE;
          cas_oe_n  = 1'b0;
        end else if (expired) begin
          state_n     = IDLE;
          cas_oe_n    = 1'b0;
          seq_error_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign cas_out   = cas_out_q;
  assign cas_oe    = cas_oe_q;
  assign ack_set   = ack_set_q;
  assign ack_level = lvl_q;
  assign seq_error = seq_error_q;

endmodule

// File: tb/tb_cascade_sequencer.sv
// Bench for cascade_sequencer: directed scenarios plus randomized INTA
// sequences compared against a rule-level reference model.
module tb_cascade_sequencer;

  localparam int CAS_W = 3;
  localparam int NP    = 8;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             reset, sp, sngl, upm, ir_valid, inta;
  logic [NP-1:0]    icw3;
  logic [CAS_W-1:0] ir_level, cas_in;
  logic [CAS_W-1:0] cas_out, ack_level;
  logic             cas_oe, vec_oe, ack_set, busy, seq_error;
  logic [1:0]       vec_phase;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cascade_sequencer #(.CAS_W(CAS_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .sp(sp), .sngl(sngl), .upm(upm), .icw3(icw3),
    .ir_level(ir_level), .ir_valid(ir_valid), .inta(inta), .cas_in(cas_in),
    .cas_out(cas_out), .cas_oe(cas_oe), .vec_oe(vec_oe), .vec_phase(vec_phase),
    .ack_set(ack_set), .ack_level(ack_level), .busy(busy), .seq_error(seq_error)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One INTA strobe; returns what the DUT presents during the strobe cycle.
  task automatic pulse(output logic v, output logic [1:0] ph, output logic oe);
    inta = 1'b1;
    @(negedge clk);
    v = vec_oe; ph = vec_phase; oe = cas_oe;
    step();
    inta = 1'b0;
  endtask

  task automatic cfg(input logic s, input logic sg, input logic u, input logic [7:0] i3,
                     input logic [2:0] lv, input logic vl, input logic [2:0] ci);
    sp = s; sngl = sg; upm = u; icw3 = i3; ir_level = lv; ir_valid = vl; cas_in = ci;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    @(negedge clk);
    total++; if (cas_out !== 3'd7) begin bad++; $display("FAIL rst_cas_out got=%0h exp=7", cas_out); end
    total++; if (ack_level !== 3'd7) begin bad++; $display("FAIL rst_ack_level got=%0h exp=7", ack_level); end
    total++; if ({cas_oe, vec_oe, vec_phase, ack_set, busy, seq_error} !== 7'b0) begin
      bad++; $display("FAIL rst_outputs got=%b exp=0", {cas_oe, vec_oe, vec_phase, ack_set, busy, seq_error}); end
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    total++; if ({vec_oe, ack_set, busy} !== 3'b0) begin bad++; $display("FAIL idle_quiet got=%b exp=0", {vec_oe, ack_set, busy}); end
    step();
  endtask

  // Master, 8086, level owned by a slave: CAS driven, master stays off the bus.
  task automatic test_master_cascade();
    logic v, oe; logic [1:0] ph;
    cfg(1, 0, 1, 8'h04, 3'd2, 1, 3'd0);
    pulse(v, ph, oe);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL mc_p1_vec_oe got=%b exp=0", v); end
    @(negedge clk);
    total++; if (ack_set !== 1'b1) begin bad++; $display("FAIL mc_ack_set got=%b exp=1", ack_set); end
    total++; if (ack_level !== 3'd2) begin bad++; $display("FAIL mc_ack_level got=%0d exp=2", ack_level); end
    total++; if (cas_out !== 3'd2) begin bad++; $display("FAIL mc_cas_out got=%0d exp=2", cas_out); end
    total++; if (cas_oe !== 1'b1) begin bad++; $display("FAIL mc_cas_oe_t11 got=%b exp=1", cas_oe); end
    step(); @(negedge clk);
    total++; if (ack_set !== 1'b0) begin bad++; $display("FAIL mc_ack_single got=%b exp=0", ack_set); end
    step(); @(negedge clk);
    total++; if (cas_oe !== 1'b1) begin bad++; $display("FAIL mc_cas_oe_t13 got=%b exp=1", cas_oe); end
    step();
    pulse(v, ph, oe);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL mc_p2_vec_oe got=%b exp=0", v); end
    total++; if (oe !== 1'b1) begin bad++; $display("FAIL mc_cas_oe_t14 got=%b exp=1", oe); end
    @(negedge clk);
    total++; if ({cas_oe, busy} !== 2'b00) begin bad++; $display("FAIL mc_end got=%b exp=00", {cas_oe, busy}); end
    step();
  endtask

  // Master, level not behind a slave: master supplies the vector itself.
  task automatic test_master_direct();
    logic v, oe; logic [1:0] ph;
    cfg(1, 0, 1, 8'h04, 3'd5, 1, 3'd0);
    pulse(v, ph, oe);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL md_p1_vec_oe got=%b exp=0", v); end
    @(negedge clk);
    total++; if (cas_oe !== 1'b0) begin bad++; $display("FAIL md_cas_oe got=%b exp=0", cas_oe); end
    total++; if (ack_level !== 3'd5 || ack_set !== 1'b1) begin
      bad++; $display("FAIL md_ack got=%b/%0d exp=1/5", ack_set, ack_level); end
    step();
    pulse(v, ph, oe);
    total++; if (v !== 1'b1 || ph !== 2'd1) begin bad++; $display("FAIL md_p2 got=%b/%0d exp=1/1", v, ph); end
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL md_p2_cas_oe got=%b exp=0", oe); end
    step();
  endtask

  // Slave, 8080: selected only when CAS matches its ID.
  task automatic test_slave();
    logic v, oe; logic [1:0] ph;
    for (int r = 0; r < 2; r++) begin
      logic hit;
      hit = (r == 0);
      cfg(0, 0, 0, 8'h03, 3'd6, 1, 3'd0);
      pulse(v, ph, oe);
      total++; if (v !== 1'b0) begin bad++; $display("FAIL sl%0d_p1_vec_oe got=%b exp=0", r, v); end
      @(negedge clk);
      total++; if (ack_set !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL sl%0d_after_p1 got=%b%b exp=01", r, ack_set, busy); end
      step();
      cas_in = hit ? 3'd3 : 3'd4;
      pulse(v, ph, oe);
      total++; if (v !== hit || (hit && ph !== 2'd1)) begin
        bad++; $display("FAIL sl%0d_p2 got=%b/%0d exp=%b/1", r, v, ph, hit); end
      @(negedge clk);
      total++; if (ack_set !== hit) begin bad++; $display("FAIL sl%0d_ack got=%b exp=%b", r, ack_set, hit); end
      if (hit) begin
        total++; if (ack_level !== 3'd6) begin bad++; $display("FAIL sl_ack_level got=%0d exp=6", ack_level); end
      end
      step();
      cas_in = 3'd0;
      pulse(v, ph, oe);
      total++; if (v !== hit || (hit && ph !== 2'd2)) begin
        bad++; $display("FAIL sl%0d_p3 got=%b/%0d exp=%b/2", r, v, ph, hit); end
      @(negedge clk);
      total++; if (busy !== 1'b0 || ack_set !== 1'b0) begin
        bad++; $display("FAIL sl%0d_end got=%b%b exp=00", r, busy, ack_set); end
      step();
    end
  endtask

  task automatic test_timeout();
    logic v, oe; logic [1:0] ph;
    int hits, first;
    cfg(1, 0, 1, 8'h04, 3'd2, 1, 3'd0);
    pulse(v, ph, oe);
    hits = 0; first = -1;
    for (int k = 1; k <= TO + 2; k++) begin
      @(negedge clk);
      if (seq_error) begin hits++; if (first < 0) first = k; end
      if (k == TO) begin
        total++; if ({busy, cas_oe} !== 2'b11) begin bad++; $display("FAIL to_before got=%b exp=11", {busy, cas_oe}); end
      end
      if (k == TO + 1) begin
        total++; if ({busy, cas_oe, vec_oe} !== 3'b000) begin
          bad++; $display("FAIL to_after got=%b exp=000", {busy, cas_oe, vec_oe}); end
      end
      step();
    end
    total++; if (hits !== 1 || first !== TO + 1) begin
      bad++; $display("FAIL to_seq_error pulses=%0d at=%0d exp=1 at %0d", hits, first, TO + 1); end
    // Fresh sequence after the abort.
    cfg(1, 0, 1, 8'h00, 3'd5, 1, 3'd0);
    pulse(v, ph, oe);
    @(negedge clk);
    total++; if ({busy, ack_set} !== 2'b11 || ack_level !== 3'd5) begin
      bad++; $display("FAIL to_fresh_p1 got=%b%b/%0d exp=11/5", busy, ack_set, ack_level); end
    step();
    pulse(v, ph, oe);
    total++; if (v !== 1'b1 || ph !== 2'd1) begin bad++; $display("FAIL to_fresh_p2 got=%b/%0d exp=1/1", v, ph); end
    step();
    // A pulse landing exactly on the expiry cycle still completes the sequence.
    pulse(v, ph, oe);
    repeat (TO - 1) step();
    pulse(v, ph, oe);
    total++; if (v !== 1'b1 || ph !== 2'd1) begin bad++; $display("FAIL to_edge_p2 got=%b/%0d exp=1/1", v, ph); end
    @(negedge clk);
    total++; if ({seq_error, busy} !== 2'b00) begin
      bad++; $display("FAIL to_edge_end got=%b%b exp=00", seq_error, busy); end
    step();
  endtask

  task automatic test_spurious();
    logic v, oe; logic [1:0] ph;
    cfg(1, 0, 1, 8'hFF, 3'd3, 0, 3'd0);
    pulse(v, ph, oe);
    @(negedge clk);
    total++; if (ack_set !== 1'b0) begin bad++; $display("FAIL sp_ack_set got=%b exp=0", ack_set); end
    total++; if (ack_level !== 3'd7 || cas_oe !== 1'b0) begin
      bad++; $display("FAIL sp_level got=%0d oe=%b exp=7 oe=0", ack_level, cas_oe); end
    step();
    pulse(v, ph, oe);
    total++; if (v !== 1'b1 || ph !== 2'd1) begin bad++; $display("FAIL sp_p2 got=%b/%0d exp=1/1", v, ph); end
    step();
  endtask

  task automatic test_reset_mid();
    logic v, oe; logic [1:0] ph;
    int hits;
    cfg(1, 0, 1, 8'h04, 3'd2, 1, 3'd0);
    pulse(v, ph, oe);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    total++; if ({busy, cas_oe, seq_error} !== 3'b000 || ack_level !== 3'd7) begin
      bad++; $display("FAIL rm_state got=%b/%0d exp=000/7", {busy, cas_oe, seq_error}, ack_level); end
    hits = 0;
    for (int k = 0; k < TO + 4; k++) begin step(); @(negedge clk); if (seq_error) hits++; end
    total++; if (hits !== 0) begin bad++; $display("FAIL rm_seq_error pulses=%0d exp=0", hits); end
    step();
  endtask

  // 8080 master with cascaded level 0; resolver level moves after pulse 1.
  task automatic test_freeze_8080();
    logic v, oe; logic [1:0] ph;
    cfg(1, 0, 0, 8'h01, 3'd0, 1, 3'd0);
    pulse(v, ph, oe);
    total++; if (v !== 1'b1 || ph !== 2'd0) begin bad++; $display("FAIL fr_p1 got=%b/%0d exp=1/0", v, ph); end
    ir_level = 3'd3;
    @(negedge clk);
    total++; if (cas_oe !== 1'b1 || cas_out !== 3'd0) begin
      bad++; $display("FAIL fr_cas got=%b/%0d exp=1/0", cas_oe, cas_out); end
    step();
    pulse(v, ph, oe);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL fr_p2_vec_oe got=%b exp=0", v); end
    @(negedge clk);
    total++; if (cas_out !== 3'd0 || ack_level !== 3'd0) begin
      bad++; $display("FAIL fr_hold got=%0d/%0d exp=0/0", cas_out, ack_level); end
    step();
    pulse(v, ph, oe);
    total++; if (v !== 1'b0 || oe !== 1'b1) begin bad++; $display("FAIL fr_p3 got=%b oe=%b exp=0 oe=1", v, oe); end
    @(negedge clk);
    total++; if ({cas_oe, busy} !== 2'b00 || cas_out !== 3'd0) begin
      bad++; $display("FAIL fr_end got=%b/%0d exp=00/0", {cas_oe, busy}, cas_out); end
    step();
  endtask

  task automatic test_random();
    logic v, oe; logic [1:0] ph;
    logic m_sp, m_sngl, m_upm, m_vld, e_casc, e_sel, e_ack2;
    logic [7:0] m_icw3;
    logic [2:0] m_lev, m_cas, e_lvl;
    int gap, npulse;
    for (int it = 0; it < 60; it++) begin
      m_sp = 1'($urandom); m_sngl = 1'($urandom); m_upm = 1'($urandom);
      m_icw3 = 8'($urandom); m_lev = 3'($urandom);
      m_vld = ($urandom_range(0, 3) != 0);
      m_cas = ($urandom_range(0, 1) == 1) ? m_icw3[2:0] : 3'($urandom);
      // Reference: what each pulse should produce, from the protocol rules.
      e_lvl  = m_vld ? m_lev : 3'd7;
      e_casc = m_sp && !m_sngl && m_vld && m_icw3[e_lvl];
      e_sel  = m_sp ? !e_casc : (!m_sngl && (m_cas == m_icw3[2:0]));
      e_ack2 = !m_sp && e_sel && m_vld;
      npulse = m_upm ? 2 : 3;
      cfg(m_sp, m_sngl, m_upm, m_icw3, m_lev, m_vld, m_cas);
      pulse(v, ph, oe);
      total++; if (v !== (m_sp && !m_upm) || (v && ph !== 2'd0)) begin
        bad++; $display("FAIL rnd%0d_p1 got=%b/%0d exp=%b/0", it, v, ph, m_sp && !m_upm); end
      @(negedge clk);
      total++; if (ack_set !== (m_sp && m_vld) || cas_oe !== e_casc || busy !== 1'b1) begin
        bad++; $display("FAIL rnd%0d_after_p1 ack=%b oe=%b busy=%b exp=%b %b 1", it, ack_set, cas_oe, busy, m_sp && m_vld, e_casc); end
      if (m_sp) begin
        total++; if (ack_level !== e_lvl || cas_out !== e_lvl) begin
          bad++; $display("FAIL rnd%0d_lvl got=%0d/%0d exp=%0d", it, ack_level, cas_out, e_lvl); end
        ir_level = 3'($urandom);
      end
      sp = 1'($urandom); sngl = 1'($urandom); upm = 1'($urandom); icw3 = 8'($urandom);
      for (int p = 2; p <= npulse; p++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          step(); @(negedge clk);
          total++; if ({vec_oe, ack_set, busy} !== 3'b001) begin
            bad++; $display("FAIL rnd%0d_gap got=%b exp=001", it, {vec_oe, ack_set, busy}); end
        end
        step();
        pulse(v, ph, oe);
        total++; if (v !== e_sel || (e_sel && ph !== 2'(p - 1))) begin
          bad++; $display("FAIL rnd%0d_p%0d got=%b/%0d exp=%b/%0d", it, p, v, ph, e_sel, p - 1); end
        @(negedge clk);
        total++; if (ack_set !== (p == 2 && e_ack2)) begin
          bad++; $display("FAIL rnd%0d_ack_p%0d got=%b exp=%b", it, p, ack_set, p == 2 && e_ack2); end
        if (p == 2 && e_ack2) begin
          total++; if (ack_level !== m_lev) begin bad++; $display("FAIL rnd%0d_slv_lvl got=%0d exp=%0d", it, ack_level, m_lev); end
        end
        total++; if (busy !== (p < npulse) || cas_oe !== (p < npulse && e_casc)) begin
          bad++; $display("FAIL rnd%0d_state_p%0d busy=%b oe=%b exp=%b %b", it, p, busy, cas_oe, p < npulse, p < npulse && e_casc); end
        if (m_sp) begin
          total++; if (cas_out !== e_lvl) begin bad++; $display("FAIL rnd%0d_frozen got=%0d exp=%0d", it, cas_out, e_lvl); end
        end
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; inta = 1'b0;
    cfg(0, 0, 0, 8'h00, 3'd0, 0, 3'd0);
    test_reset();
    test_master_cascade();
    test_master_direct();
    test_slave();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_freeze_8080();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
